// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int LANES = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/lsu_if.sv
// Memory-side valid/ready bus of the LSU; master is the LSU, slave is the memory.
interface lsu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              bus_req_valid;
   logic              bus_req_ready;
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_wen;
   logic [DATA_W-1:0] bus_wdata;
   logic [3:0]        bus_wmask;
   logic              bus_rsp_valid;
   logic [DATA_W-1:0] bus_rdata;

   modport master (
      output bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wmask,
      input  bus_req_ready, bus_rsp_valid, bus_rdata
   );

   modport slave (
      input  bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wmask,
      output bus_req_ready, bus_rsp_valid, bus_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/replication and load lane select with extension.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        size_i,
   input  logic [1:0]        off_i,
   input  logic              uns_i,
   input  logic [DATA_W-1:0] sdata_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [3:0]        wmask_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [DATA_W-1:0] ldata_o
);

   function automatic logic [DATA_W-1:0] ext8(input logic [7:0] b, input logic uns);
      logic signed [7:0] s;
      s = b;
      return uns ? {{(DATA_W-8){1'b0}}, b} : DATA_W'(s);
   endfunction

   function automatic logic [DATA_W-1:0] ext16(input logic [15:0] h, input logic uns);
      logic signed [15:0] s;
      s = h;
      return uns ? {{(DATA_W-16){1'b0}}, h} : DATA_W'(s);
   endfunction

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[{off_i, 3'b000} +: 8];
      half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      wmask_o  = 4'b1111;
      wdata_o  = sdata_i;
      ldata_o  = rdata_i;
      case (size_i)
         SZ_BYTE: begin
            wmask_o = 4'b0001 << off_i;
            wdata_o = {LANES{sdata_i[7:0]}};
            ldata_o = ext8(byte_sel, uns_i);
         end
         SZ_HALF: begin
            // Halves ignore off[0]; misaligned halves land on the containing half-word.
            wmask_o = 4'b0011 << {off_i[1], 1'b0};
            wdata_o = {(LANES/2){sdata_i[15:0]}};
            ldata_o = ext16(half_sel, uns_i);
         end
         default: begin
            wmask_o = 4'b1111;
            wdata_o = sdata_i;
            ldata_o = rdata_i;
         end
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit, one instruction in flight, IDLE/REQ/WAIT/DONE FSM.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] exu_data,
   input  logic [DATA_W-1:0] store_data,
   input  logic              mem_ren,
   input  logic              mem_wen_in,
   input  logic [1:0]        mem_size,
   input  logic              mem_unsigned,
   input  logic [4:0]        rd_in,
   input  logic              rd_wen_in,
   lsu_if.master             bus,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic [4:0]        rd_out,
`ifdef LSU_MISALIGN_CHECK_EN
   output logic              misalign,
`endif
   output logic              rd_wen_out
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] sd_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic              wen_q;
   logic [4:0]        rd_q;
   logic              rdwen_q;
   logic [DATA_W-1:0] wb_q, wb_d;
   logic              accept;
   logic              is_mem;
   logic              rsp_take;
   logic              mis_now;
   logic [3:0]        al_wmask;
   logic [DATA_W-1:0] al_wdata;
   logic [DATA_W-1:0] al_ldata;

   lsu_align #(.DATA_W(DATA_W)) u_align (
      .size_i  (size_q),
      .off_i   (addr_q[1:0]),
      .uns_i   (uns_q),
      .sdata_i (sd_q),
      .rdata_i (bus.bus_rdata),
      .wmask_o (al_wmask),
      .wdata_o (al_wdata),
      .ldata_o (al_ldata)
   );

   assign accept   = (state_q == ST_IDLE) && in_valid;
   assign is_mem   = mem_ren || mem_wen_in;
   // A response is only meaningful once the request is (or is being) accepted.
   assign rsp_take = bus.bus_rsp_valid &&
                     ((state_q == ST_WAIT) || ((state_q == ST_REQ) && bus.bus_req_ready));

`ifdef LSU_MISALIGN_CHECK_EN
   assign mis_now = is_mem &&
                    (((mem_size == SZ_HALF) && exu_data[0]) ||
                     (mem_size[1] && (exu_data[1:0] != 2'b00)));
`else
   assign mis_now = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      wb_d    = wb_q;
      case (state_q)
         ST_IDLE: if (in_valid) begin
            wb_d    = is_mem ? '0 : exu_data;
            state_d = (is_mem && !mis_now) ? ST_REQ : ST_DONE;
         end
         ST_REQ: if (bus.bus_req_ready) state_d = bus.bus_rsp_valid ? ST_DONE : ST_WAIT;
         ST_WAIT: if (bus.bus_rsp_valid) state_d = ST_DONE;
         default: if (out_ready) state_d = ST_IDLE;
      endcase
      if (rsp_take) wb_d = wen_q ? '0 : al_ldata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         sd_q    <= '0;
         size_q  <= SZ_BYTE;
         uns_q   <= 1'b0;
         wen_q   <= 1'b0;
         rd_q    <= '0;
         rdwen_q <= 1'b0;
         wb_q    <= '0;
      end else begin
         wb_q <= wb_d;
         if (accept) begin
            addr_q  <= exu_data[ADDR_W-1:0];
            sd_q    <= store_data;
            size_q  <= mem_size;
            uns_q   <= mem_unsigned;
            wen_q   <= mem_wen_in;
            rd_q    <= rd_in;
            rdwen_q <= rd_wen_in && !mem_wen_in && !mis_now;
         end
      end
   end

`ifdef LSU_MISALIGN_CHECK_EN
   logic mis_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      mis_q <= 1'b0;
      else if (accept) mis_q <= mis_now;
   end
   assign misalign = mis_q;
`endif

   always_comb begin
      in_ready          = (state_q == ST_IDLE);
      out_valid         = (state_q == ST_DONE);
      bus.bus_req_valid = (state_q == ST_REQ);
      bus.bus_addr      = '0;
      bus.bus_wen       = 1'b0;
      bus.bus_wdata     = '0;
      bus.bus_wmask     = 4'b0000;
      if (state_q == ST_REQ) begin
         bus.bus_addr = {addr_q[ADDR_W-1:2], 2'b00};
         bus.bus_wen  = wen_q;
         if (wen_q) begin
            bus.bus_wdata = al_wdata;
            bus.bus_wmask = al_wmask;
         end
      end
      wb_data    = wb_q;
      rd_out     = rd_q;
      rd_wen_out = rdwen_q;
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: reset, non-memory, store/load lanes, stalls, mid-op reset.
module tb_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] exu_data = '0;
   logic [31:0] store_data = '0;
   logic        mem_ren = 1'b0;
   logic        mem_wen_in = 1'b0;
   logic [1:0]  mem_size = 2'b00;
   logic        mem_unsigned = 1'b0;
   logic [4:0]  rd_in = '0;
   logic        rd_wen_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] wb_data;
   logic [4:0]  rd_out;
   logic        rd_wen_out;
`ifdef LSU_MISALIGN_CHECK_EN
   logic        misalign;
`endif

   int vectors = 0;
   int miscompares = 0;

   lsu_if bus ();

   lsu dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .exu_data     (exu_data),
      .store_data   (store_data),
      .mem_ren      (mem_ren),
      .mem_wen_in   (mem_wen_in),
      .mem_size     (mem_size),
      .mem_unsigned (mem_unsigned),
      .rd_in        (rd_in),
      .rd_wen_in    (rd_wen_in),
      .bus          (bus),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .wb_data      (wb_data),
      .rd_out       (rd_out),
`ifdef LSU_MISALIGN_CHECK_EN
      .misalign     (misalign),
`endif
      .rd_wen_out   (rd_wen_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Present one instruction for a single cycle; returns at the negedge after acceptance.
   task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic ren,
                        input logic wen, input logic [1:0] sz, input logic uns,
                        input logic [4:0] rd, input logic rdw);
      exu_data = a; store_data = sd; mem_ren = ren; mem_wen_in = wen;
      mem_size = sz; mem_unsigned = uns; rd_in = rd; rd_wen_in = rdw;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0; mem_ren = 1'b0; mem_wen_in = 1'b0;
   endtask

   task automatic retire(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_retired"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
   endtask

   // Load with immediate request grant; split=1 answers one cycle after the grant.
   task automatic load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                       input logic uns, input logic split, input logic [31:0] rdata,
                       input logic [31:0] exp);
      issue(a, 32'h0, 1'b1, 1'b0, sz, uns, 5'd3, 1'b1);
      chk({tag, "_req"}, {31'b0, bus.bus_req_valid}, 32'd1);
      chk({tag, "_rmask"}, {28'b0, bus.bus_wmask}, 32'd0);
      bus.bus_rdata = rdata;
      bus.bus_req_ready = 1'b1;
      bus.bus_rsp_valid = !split;
      tick();
      bus.bus_req_ready = 1'b0;
      if (split) begin
         chk({tag, "_wait"}, {31'b0, out_valid}, 32'd0);
         bus.bus_rsp_valid = 1'b1;
         tick();
      end
      bus.bus_rsp_valid = 1'b0;
      chk({tag, "_ovalid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_wb"}, wb_data, exp);
      chk({tag, "_rdwen"}, {31'b0, rd_wen_out}, 32'd1);
      retire(tag);
   endtask

   initial begin
      bus.bus_req_ready = 1'b0;
      bus.bus_rsp_valid = 1'b0;
      bus.bus_rdata     = '0;

      // Reset state
      tick();
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_req_valid", {31'b0, bus.bus_req_valid}, 32'd0);
      chk("rst_wen", {31'b0, bus.bus_wen}, 32'd0);
      chk("rst_addr", bus.bus_addr, 32'd0);
      chk("rst_wdata", bus.bus_wdata, 32'd0);
      chk("rst_wmask", {28'b0, bus.bus_wmask}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_wb", wb_data, 32'd0);
      chk("rst_rd", {27'b0, rd_out}, 32'd0);
      chk("rst_rdwen", {31'b0, rd_wen_out}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Non-memory op passes EXU result straight through
      issue(32'h1234_5678, 32'h0, 1'b0, 1'b0, SZ_WORD, 1'b0, 5'd5, 1'b1);
      chk("alu_ovalid", {31'b0, out_valid}, 32'd1);
      chk("alu_wb", wb_data, 32'h1234_5678);
      chk("alu_rd", {27'b0, rd_out}, 32'd5);
      chk("alu_rdwen", {31'b0, rd_wen_out}, 32'd1);
      chk("alu_noreq", {31'b0, bus.bus_req_valid}, 32'd0);
      chk("alu_busy", {31'b0, in_ready}, 32'd0);
      retire("alu");

      // Store byte at offset 3, response in the handshake cycle
      issue(32'h8000_0003, 32'hAABB_CCDD, 1'b0, 1'b1, SZ_BYTE, 1'b0, 5'd7, 1'b1);
      chk("sb_req", {31'b0, bus.bus_req_valid}, 32'd1);
      chk("sb_addr", bus.bus_addr, 32'h8000_0000);
      chk("sb_wen", {31'b0, bus.bus_wen}, 32'd1);
      chk("sb_wmask", {28'b0, bus.bus_wmask}, 32'h8);
      chk("sb_wdata", bus.bus_wdata, 32'hDDDD_DDDD);
      bus.bus_req_ready = 1'b1;
      bus.bus_rsp_valid = 1'b1;
      tick();
      bus.bus_req_ready = 1'b0;
      bus.bus_rsp_valid = 1'b0;
      chk("sb_ovalid", {31'b0, out_valid}, 32'd1);
      chk("sb_wb", wb_data, 32'd0);
      chk("sb_rdwen", {31'b0, rd_wen_out}, 32'd0);
      retire("sb");

      // Store half at offset 2 and word store
      issue(32'h8000_0012, 32'h1234_ABCD, 1'b0, 1'b1, SZ_HALF, 1'b0, 5'd1, 1'b0);
      chk("sh_addr", bus.bus_addr, 32'h8000_0010);
      chk("sh_wmask", {28'b0, bus.bus_wmask}, 32'hC);
      chk("sh_wdata", bus.bus_wdata, 32'hABCD_ABCD);
      bus.bus_req_ready = 1'b1; bus.bus_rsp_valid = 1'b1;
      tick();
      bus.bus_req_ready = 1'b0; bus.bus_rsp_valid = 1'b0;
      retire("sh");
      issue(32'h8000_0020, 32'hCAFE_F00D, 1'b0, 1'b1, 2'b11, 1'b0, 5'd1, 1'b0);
      chk("sw_wmask", {28'b0, bus.bus_wmask}, 32'hF);
      chk("sw_wdata", bus.bus_wdata, 32'hCAFE_F00D);
      bus.bus_req_ready = 1'b1; bus.bus_rsp_valid = 1'b1;
      tick();
      bus.bus_req_ready = 1'b0; bus.bus_rsp_valid = 1'b0;
      retire("sw");

      // Loads: byte signed/unsigned, half low lane unsigned, word ignores unsigned
      load("lb_s", 32'h8000_0001, SZ_BYTE, 1'b0, 1'b1, 32'h1122_8344, 32'hFFFF_FF83);
      load("lb_u", 32'h8000_0001, SZ_BYTE, 1'b1, 1'b0, 32'h1122_8344, 32'h0000_0083);
      load("lh_u", 32'h8000_0000, SZ_HALF, 1'b1, 1'b1, 32'h1234_9ABC, 32'h0000_9ABC);
      load("lw_u", 32'h8000_0004, SZ_WORD, 1'b1, 1'b0, 32'h8000_0001, 32'h8000_0001);

      // Load half with request backpressure, delayed response and output stall
      issue(32'h8000_0002, 32'h0, 1'b1, 1'b0, SZ_HALF, 1'b0, 5'd9, 1'b1);
      bus.bus_rdata = 32'hBEEF_0000;
      for (int i = 0; i < 3; i++) begin
         chk("lh_hold_req", {31'b0, bus.bus_req_valid}, 32'd1);
         chk("lh_hold_addr", bus.bus_addr, 32'h8000_0000);
         tick();
      end
      bus.bus_req_ready = 1'b1;
      tick();
      bus.bus_req_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("lh_wait_req", {31'b0, bus.bus_req_valid}, 32'd0);
         chk("lh_wait_ovalid", {31'b0, out_valid}, 32'd0);
         tick();
      end
      bus.bus_rsp_valid = 1'b1;
      tick();
      bus.bus_rsp_valid = 1'b0;
      bus.bus_rdata = 32'h0;
      for (int i = 0; i < 2; i++) begin
         chk("lh_stall_ovalid", {31'b0, out_valid}, 32'd1);
         chk("lh_stall_wb", wb_data, 32'hFFFF_BEEF);
         tick();
      end
      chk("lh_rd", {27'b0, rd_out}, 32'd9);
      retire("lh");

      // Reset while waiting for a response, then a stale response
      issue(32'h8000_0008, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0, 5'd4, 1'b1);
      bus.bus_req_ready = 1'b1;
      tick();
      bus.bus_req_ready = 1'b0;
      chk("mid_in_wait", {31'b0, in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_async_ready", {31'b0, in_ready}, 32'd1);
      tick();
      rst_n = 1'b1;
      bus.bus_rsp_valid = 1'b1;
      bus.bus_rdata = 32'h5555_AAAA;
      tick();
      bus.bus_rsp_valid = 1'b0;
      chk("stale_ovalid", {31'b0, out_valid}, 32'd0);
      chk("stale_in_ready", {31'b0, in_ready}, 32'd1);
      chk("stale_req", {31'b0, bus.bus_req_valid}, 32'd0);
      tick();
      chk("stale_ovalid2", {31'b0, out_valid}, 32'd0);

`ifdef LSU_MISALIGN_CHECK_EN
      // Misaligned word load traps without touching the bus
      issue(32'h8000_0002, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0, 5'd6, 1'b1);
      chk("mis_req", {31'b0, bus.bus_req_valid}, 32'd0);
      chk("mis_ovalid", {31'b0, out_valid}, 32'd1);
      chk("mis_flag", {31'b0, misalign}, 32'd1);
      chk("mis_wb", wb_data, 32'd0);
      chk("mis_rdwen", {31'b0, rd_wen_out}, 32'd0);
      retire("mis");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the execute unit in the NPC core.
- Takes EXU_data (the ALU result, used as the effective address for loads and stores) plus the store operand (gpr_rdata2), and runs one memory transaction over a valid/ready bus.
- Returns write-back data: the aligned and extended load value, or the EXU result passed through for non-memory ops.
- Multi-cycle: at most one instruction in flight; upstream is stalled via in_ready.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32, because byte lanes are fixed at 4.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction from EXU valid.
- in_ready  out  1  LSU can accept.
- exu_data  in  32  EXU result / effective address.
- store_data  in  32  rs2 value for stores.
- mem_ren  in  1  op is load.
- mem_wen_in  in  1  op is store; mem_ren and mem_wen_in must never both be 1.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- mem_unsigned  in  1  zero-extend load.
- rd_in  in  5  destination register.
- rd_wen_in  in  1  register write enable.
- bus_req_valid  out  1  memory request valid.
- bus_req_ready  in  1  memory accepts request.
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- bus_wen  out  1  request is write.
- bus_wdata  out  32  lane-replicated store data.
- bus_wmask  out  4  byte enables (write only; 0 on read).
- bus_rsp_valid  in  1  response valid (read data or write ack).
- bus_rdata  in  32  read word.
- out_valid  out  1  write-back data valid.
- out_ready  in  1  write-back stage accepts.
- wb_data  out  32  write-back value.
- rd_out  out  5  registered rd_in.
- rd_wen_out  out  1  registered rd_wen_in; forced to 0 for stores.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - in_ready=1.
  - bus_req_valid=0, bus_wen=0, bus_addr=0, bus_wdata=0, bus_wmask=0.
  - out_valid=0, wb_data=0, rd_out=0, rd_wen_out=0.
- State machine: IDLE, REQ, WAIT, DONE.
  - IDLE: in_ready=1. On in_valid, all inputs are captured into registers.
    - Load or store: go to REQ.
    - Otherwise: wb_data<=exu_data and go to DONE.
  - REQ: bus_req_valid=1, with address/wen/wdata/wmask stable until bus_req_ready. Request handshake → WAIT.
    - bus_rsp_valid arriving in the same cycle as the handshake is legal and is taken: go straight to DONE.
  - WAIT: hold until bus_rsp_valid.
    - Load: wb_data <= extended lane of bus_rdata.
    - Store: wb_data <= 0.
    - Then go to DONE.
  - DONE: out_valid=1, outputs held stable until out_ready, then go to IDLE. No new accept in the same cycle (in_ready=0 outside IDLE).
- Latency (all waits zero):
  - Non-memory op: out_valid 1 cycle after accept.
  - Memory op: bus_req_valid 1 cycle after accept; out_valid 1 cycle after bus_rsp_valid.
- Lane rules (off = exu_data[1:0]):
  - Byte: wmask = 4'b0001<<off; wdata = {4{sd[7:0]}}.
  - Half: wmask = 4'b0011<<{off[1],1'b0}; wdata = {2{sd[15:0]}}.
  - Word: wmask = 4'b1111; wdata = sd.
  - Load: select the byte/half at that offset, then sign- or zero-extend per mem_unsigned. Word loads ignore mem_unsigned.
- bus_rsp_valid outside WAIT/REQ is ignored. This includes a stale response arriving after a reset mid-transaction.
- Reset mid-operation: the transaction is abandoned, the FSM returns to IDLE, and no out_valid is produced for that instruction.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - Adds an output misalign (1 bit, reset 0), registered with out_valid.
  - Half at off[0]=1, or word at off≠0, skips REQ entirely and goes IDLE→DONE.
  - In that case: misalign=1, wb_data=0, rd_wen_out=0, and no bus request is issued.
- Undefined:
  - No port.
  - Half uses off[1] only; word ignores off.
  - The access always proceeds.

Decomposition:
- Package lsu_pkg:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State encoding constants ST_IDLE, ST_REQ, ST_WAIT, ST_DONE.
- Sub-module lsu_align (combinational): from size, off, store data and read word, it produces wmask, wdata and the extended load data. The FSM stays in lsu.

Test Plan:
- Non-mem op, exu_data=0x1234_5678, rd_in=5 → out_valid next cycle, wb_data=0x12345678, rd_out=5, no bus_req_valid.
- Store byte, addr=0x8000_0003, store_data=0xAABBCCDD → bus_addr=0x80000000, bus_wmask=4'b1000, bus_wdata=0xDDDDDDDD, rd_wen_out=0.
- Load byte, addr=0x8000_0001, bus_rdata=0x11228344:
  - Signed → wb_data=0xFFFFFF83.
  - mem_unsigned=1 → wb_data=0x00000083.
- Load half, addr=…2, bus_rdata=0xBEEF0000, bus_req_ready held low 3 cycles and response delayed 2 → request held stable, wb_data=0xFFFFBEEF, out_valid held while out_ready=0.
- rst_n low while in WAIT, then bus_rsp_valid pulse after release → no out_valid, in_ready=1, state IDLE.
- (LSU_MISALIGN_CHECK_EN) Word load at addr=0x8000_0002 → no bus_req_valid, out_valid with misalign=1, wb_data=0.
